// File: rtl/pio_irq_master_pkg.sv
// Shared types and constants for the PIO interrupt-servicing master.
// Holds the FSM state encoding, PIO register map and bus-cycle decode.
package pio_irq_master_pkg;

    typedef enum logic [2:0] {
        ST_INIT_MASK = 3'd0,
        ST_INIT_CLR  = 3'd1,
        ST_IDLE      = 3'd2,
        ST_ACK       = 3'd3,
        ST_RD        = 3'd4,
        ST_RD_CAP    = 3'd5,
        ST_EMIT      = 3'd6,
        ST_HOLD      = 3'd7
    } state_t;

    localparam logic [1:0]  ADDR_DATA = 2'd0;
    localparam logic [1:0]  ADDR_MASK = 2'd2;
    localparam logic [1:0]  ADDR_EDGE = 2'd3;
    localparam logic [31:0] WDATA_ONE = 32'd1;

    typedef struct packed {
        logic        chipselect;
        logic        write_n;
        logic [1:0]  address;
        logic [31:0] writedata;
    } bus_t;

    localparam bus_t BUS_IDLE = '{1'b0, 1'b1, ADDR_DATA, 32'd0};

    // Bus cycle driven while the FSM sits in a given state.
    function automatic bus_t bus_for_state(input state_t st);
        bus_t b;
        b = BUS_IDLE;
        case (st)
            ST_INIT_MASK:        b = '{1'b1, 1'b0, ADDR_MASK, WDATA_ONE};
            ST_INIT_CLR, ST_ACK: b = '{1'b1, 1'b0, ADDR_EDGE, WDATA_ONE};
            ST_RD:               b = '{1'b1, 1'b1, ADDR_DATA, 32'd0};
            default:             b = BUS_IDLE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pio_irq_master_if.sv
// Avalon-MM bus towards the PIO slave plus the event valid/ready stream.
interface pio_irq_master_if #(parameter int CNT_W = 16);

    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic             event_valid;
    logic             event_ready;
    logic             event_level;
    logic [CNT_W-1:0] event_count;

    modport master (
        output address, chipselect, write_n, writedata,
        output event_valid, event_level, event_count,
        input  readdata, event_ready
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        input  event_valid, event_level, event_count,
        output readdata, event_ready
    );

endinterface

// File: rtl/pio_irq_master.sv
// Hardware interrupt service loop for an edge-capture PIO: arm, clear,
// read the pin level and publish a numbered level event per interrupt.
module pio_irq_master
    import pio_irq_master_pkg::*;
#(
    parameter int HOLDOFF = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             irq,
    output logic             busy,
    pio_irq_master_if.master bus
);

    localparam int              HOLD_W    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam bit              NO_HOLD   = (HOLDOFF == 0);

    state_t            state_r, state_nxt_s;
    logic              started_r;
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nxt_s;
    bus_t              bus_r;
    logic              busy_r;
    logic              event_valid_r;
    logic              event_level_r;
    logic [CNT_W-1:0]  event_count_r;
    logic              unused_s;

    // Next-state and holdoff counter decode.
    always_comb begin
        state_nxt_s    = state_r;
        hold_cnt_nxt_s = hold_cnt_r;
        case (state_r)
            // started_r keeps INIT_MASK for one cycle after reset so its write is visible
            ST_INIT_MASK: begin
                if (started_r) state_nxt_s = ST_INIT_CLR;
                else           state_nxt_s = ST_INIT_MASK;
            end
            ST_INIT_CLR: state_nxt_s = ST_IDLE;
            ST_IDLE: begin
                if (enable && irq) state_nxt_s = ST_ACK;
                else               state_nxt_s = ST_IDLE;
            end
            ST_ACK:    state_nxt_s = ST_RD;
            ST_RD:     state_nxt_s = ST_RD_CAP;
            ST_RD_CAP: state_nxt_s = ST_EMIT;
            ST_EMIT: begin
                if (bus.event_ready) begin
                    hold_cnt_nxt_s = HOLD_LOAD;
                    if (NO_HOLD) state_nxt_s = ST_IDLE;
                    else         state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r <= HOLD_ONE) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s    = ST_HOLD;
                    hold_cnt_nxt_s = hold_cnt_r - HOLD_ONE;
                end
            end
            default: state_nxt_s = ST_INIT_MASK;
        endcase
    end

    // State register; outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_INIT_MASK;
            started_r     <= 1'b0;
            hold_cnt_r    <= '0;
            bus_r         <= BUS_IDLE;
            busy_r        <= 1'b1;
            event_valid_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            started_r     <= 1'b1;
            hold_cnt_r    <= hold_cnt_nxt_s;
            bus_r         <= bus_for_state(state_nxt_s);
            busy_r        <= (state_nxt_s != ST_IDLE);
            event_valid_r <= (state_nxt_s == ST_EMIT);
        end
    end

    // Event payload: level latched from the read, count advanced only on handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_level_r <= 1'b0;
            event_count_r <= '0;
        end else begin
            if (state_r == ST_RD_CAP) event_level_r <= bus.readdata[0];
            if ((state_r == ST_EMIT) && bus.event_ready) event_count_r <= event_count_r + CNT_W'(1);
        end
    end

    assign bus.chipselect  = bus_r.chipselect;
    assign bus.write_n     = bus_r.write_n;
    assign bus.address     = bus_r.address;
    assign bus.writedata   = bus_r.writedata;
    assign bus.event_valid = event_valid_r;
    assign bus.event_level = event_level_r;
    assign bus.event_count = event_count_r;
    assign busy            = busy_r;
    assign unused_s        = ^bus.readdata[31:1];

endmodule

// File: tb/tb_pio_irq_master.sv
// Bench for pio_irq_master: two instances (HOLDOFF=4/CNT_W=16 and HOLDOFF=0/CNT_W=2)
// against behavioural edge-capture PIO slaves, with a scoreboard of expected events.
`timescale 1ns/1ps
module tb_pio_irq_master;

    typedef struct { logic lvl; logic [15:0] cnt; } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, en_a, en_b, pin_a, pin_b, irq_a, irq_b, busy_a, busy_b;
    logic mask_a, cap_a, pin_a_d, mask_b, cap_b, pin_b_d;
    ev_t  q_a[$], q_b[$];
    ev_t  ea, eb;
    int   errors = 0, checks = 0, bus_a = 0, bus_b = 0, cnt_a = 0, cnt_b = 0;

    pio_irq_master_if #(.CNT_W(16)) ifa();
    pio_irq_master_if #(.CNT_W(2))  ifb();

    pio_irq_master #(.HOLDOFF(4), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(en_a), .irq(irq_a), .busy(busy_a), .bus(ifa.master));
    pio_irq_master #(.HOLDOFF(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(en_b), .irq(irq_b), .busy(busy_b), .bus(ifb.master));

    // PIO slave model A: any-edge capture, clear-on-write has priority over a new edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_a <= 1'b0; cap_a <= 1'b0; pin_a_d <= 1'b0; ifa.readdata <= 32'd0;
        end else begin
            pin_a_d <= pin_a;
            if (ifa.chipselect && !ifa.write_n && ifa.address == 2'd2) mask_a <= ifa.writedata[0];
            if (ifa.chipselect && !ifa.write_n && ifa.address == 2'd3 && ifa.writedata[0]) cap_a <= 1'b0;
            else if (pin_a != pin_a_d) cap_a <= 1'b1;
            if (ifa.chipselect && ifa.write_n)
                ifa.readdata <= (ifa.address == 2'd0) ? {31'd0, pin_a} :
                                (ifa.address == 2'd2) ? {31'd0, mask_a} : {31'd0, cap_a};
        end
    end
    assign irq_a = cap_a & mask_a;

    // PIO slave model B.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_b <= 1'b0; cap_b <= 1'b0; pin_b_d <= 1'b0; ifb.readdata <= 32'd0;
        end else begin
            pin_b_d <= pin_b;
            if (ifb.chipselect && !ifb.write_n && ifb.address == 2'd2) mask_b <= ifb.writedata[0];
            if (ifb.chipselect && !ifb.write_n && ifb.address == 2'd3 && ifb.writedata[0]) cap_b <= 1'b0;
            else if (pin_b != pin_b_d) cap_b <= 1'b1;
            if (ifb.chipselect && ifb.write_n)
                ifb.readdata <= (ifb.address == 2'd0) ? {31'd0, pin_b} :
                                (ifb.address == 2'd2) ? {31'd0, mask_b} : {31'd0, cap_b};
        end
    end
    assign irq_b = cap_b & mask_b;

    // Scoreboard A: every accepted event must match the oldest expected one.
    always @(negedge clk) begin
        if (reset_n) begin
            if (ifa.chipselect) bus_a++;
            if (ifa.event_valid && ifa.event_ready) begin
                checks++;
                if (q_a.size() == 0) begin
                    errors++;
                    $display("FAIL event_a_unexpected got level=%0b count=%0d expected no event", ifa.event_level, ifa.event_count);
                end else begin
                    ea = q_a.pop_front();
                    if (ifa.event_level !== ea.lvl || ifa.event_count !== ea.cnt) begin
                        errors++;
                        $display("FAIL event_a got level=%0b count=%0d expected level=%0b count=%0d",
                                 ifa.event_level, ifa.event_count, ea.lvl, ea.cnt);
                    end
                end
            end
        end
    end

    // Scoreboard B.
    always @(negedge clk) begin
        if (reset_n) begin
            if (ifb.chipselect) bus_b++;
            if (ifb.event_valid && ifb.event_ready) begin
                checks++;
                if (q_b.size() == 0) begin
                    errors++;
                    $display("FAIL event_b_unexpected got level=%0b count=%0d expected no event", ifb.event_level, ifb.event_count);
                end else begin
                    eb = q_b.pop_front();
                    if (ifb.event_level !== eb.lvl || {14'd0, ifb.event_count} !== eb.cnt) begin
                        errors++;
                        $display("FAIL event_b got level=%0b count=%0d expected level=%0b count=%0d",
                                 ifb.event_level, ifb.event_count, eb.lvl, eb.cnt);
                    end
                end
            end
        end
    end

    task automatic toggle_a();
        @(posedge clk); #1;
        pin_a = ~pin_a;
        q_a.push_back('{lvl: pin_a, cnt: 16'(cnt_a % 65536)});
        cnt_a++;
    endtask

    task automatic toggle_b();
        @(posedge clk); #1;
        pin_b = ~pin_b;
        q_b.push_back('{lvl: pin_b, cnt: 16'(cnt_b % 4)});
        cnt_b++;
    endtask

    task automatic wait_cs_a(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (ifa.chipselect) ok = 1'b1;
        end
    endtask

    task automatic wait_valid_a(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (ifa.event_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_drain_a(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            if (q_a.size() == 0) ok = 1'b1;
        end
    endtask

    task automatic wait_drain_b(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            if (q_b.size() == 0) ok = 1'b1;
        end
    endtask

    // Reset values, then INIT_MASK write, INIT_CLR write, idle with busy low.
    task automatic check_init_sequence(input string tag);
        logic [35:0] b;
        @(negedge clk);
        @(negedge clk);
        b = {ifa.chipselect, ifa.write_n, ifa.address, ifa.writedata};
        checks++;
        if (b !== {1'b1, 1'b0, 2'd2, 32'd1 } || busy_a !== 1'b1) begin
            errors++; $display("FAIL %s_init_mask got bus=%h busy=%b expected bus=%h busy=1", tag, b, busy_a, {1'b1, 1'b0, 2'd2, 32'd1});
        end
        @(negedge clk);
        b = {ifa.chipselect, ifa.write_n, ifa.address, ifa.writedata};
        checks++;
        if (b !== {1'b1, 1'b0, 2'd3, 32'd1}) begin
            errors++; $display("FAIL %s_init_clr got bus=%h expected bus=%h", tag, b, {1'b1, 1'b0, 2'd3, 32'd1});
        end
        @(negedge clk);
        checks++;
        if (ifa.chipselect !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
            errors++; $display("FAIL %s_idle got cs=%b busy_a=%b busy_b=%b expected cs=0 busy=0", tag, ifa.chipselect, busy_a, busy_b);
        end
    endtask

    task automatic test_reset();
        logic [41:0] r;
        reset_n = 1'b0; en_a = 1'b1; en_b = 1'b1; pin_a = 1'b0; pin_b = 1'b0;
        ifa.event_ready = 1'b1; ifb.event_ready = 1'b1;
        repeat (3) @(negedge clk);
        r = {ifa.chipselect, ifa.write_n, ifa.address, ifa.writedata, ifa.event_valid, ifa.event_level, ifa.event_count[3:0], busy_a};
        checks++;
        if (r !== {1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1}) begin
            errors++; $display("FAIL reset_values got %h expected %h", r, {1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1});
        end
        checks++;
        if (ifa.event_count !== 16'd0 || ifb.chipselect !== 1'b0 || busy_b !== 1'b1) begin
            errors++; $display("FAIL reset_values_b got count_a=%0d cs_b=%b busy_b=%b expected 0 0 1", ifa.event_count, ifb.chipselect, busy_b);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        check_init_sequence("reset");
    endtask

    task automatic test_service();
        bit ok;
        logic [3:0] b;
        toggle_a();
        wait_cs_a(10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL service_ack_timeout got no bus access expected ack write"); end
        b = {ifa.chipselect, ifa.write_n, ifa.address};
        checks++;
        if (b !== 4'b1011 || ifa.writedata !== 32'd1) begin
            errors++; $display("FAIL service_ack got cs/wn/addr=%b data=%0d expected 1011 data=1", b, ifa.writedata);
        end
        @(negedge clk);
        b = {ifa.chipselect, ifa.write_n, ifa.address};
        checks++;
        if (b !== 4'b1100) begin errors++; $display("FAIL service_rd got cs/wn/addr=%b expected 1100", b); end
        @(negedge clk);
        checks++;
        if (ifa.chipselect !== 1'b0 || ifa.event_valid !== 1'b0) begin
            errors++; $display("FAIL service_rdcap got cs=%b valid=%b expected 0 0", ifa.chipselect, ifa.event_valid);
        end
        @(negedge clk);
        checks++;
        if (ifa.event_valid !== 1'b1) begin errors++; $display("FAIL service_emit got valid=%b expected 1", ifa.event_valid); end
        @(negedge clk);
        checks++;
        if (ifa.event_valid !== 1'b0 || busy_a !== 1'b1) begin
            errors++; $display("FAIL service_hold got valid=%b busy=%b expected 0 1", ifa.event_valid, busy_a);
        end
        repeat (8) @(negedge clk);
        toggle_a();
        wait_drain_a(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL service_second_timeout got %0d pending expected 0", q_a.size()); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok;
        int nb;
        logic [16:0] got, exp;
        @(posedge clk); #1 ifa.event_ready = 1'b0;
        toggle_a();
        wait_valid_a(15, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_valid_timeout got valid=0 expected 1"); end
        nb = bus_a;
        toggle_a();
        exp = {q_a[0].lvl, q_a[0].cnt};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            got = {ifa.event_level, ifa.event_count};
            checks++;
            if (ifa.event_valid !== 1'b1 || got !== exp) begin
                errors++; $display("FAIL bp_hold cycle %0d got valid=%b lvl/cnt=%h expected valid=1 lvl/cnt=%h", i, ifa.event_valid, got, exp);
            end
        end
        checks++;
        if (bus_a != nb) begin errors++; $display("FAIL bp_no_bus got %0d accesses expected 0", bus_a - nb); end
        @(posedge clk); #1 ifa.event_ready = 1'b1;
        wait_drain_a(30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_drain_timeout got %0d pending expected 0", q_a.size()); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_hold_toggle();
        bit ok;
        int nb;
        logic [3:0] b;
        toggle_a();
        wait_valid_a(15, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hold_valid_timeout got valid=0 expected 1"); end
        toggle_a();
        nb = bus_a;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ifa.chipselect !== 1'b0) begin errors++; $display("FAIL hold_quiet cycle %0d got cs=1 expected 0", i); end
        end
        @(negedge clk);
        b = {ifa.chipselect, ifa.write_n, ifa.address};
        checks++;
        if (b !== 4'b1011) begin errors++; $display("FAIL hold_ack got cs/wn/addr=%b expected 1011", b); end
        repeat (20) @(negedge clk);
        checks++;
        if (bus_a - nb != 2 || q_a.size() != 0) begin
            errors++; $display("FAIL hold_one_pass got %0d accesses %0d pending expected 2 accesses 0 pending", bus_a - nb, q_a.size());
        end
    endtask

    task automatic test_enable();
        bit ok;
        int nb;
        logic [3:0] b;
        @(posedge clk); #1 en_a = 1'b0;
        toggle_a();
        nb = bus_a;
        repeat (20) @(negedge clk);
        checks++;
        if (bus_a != nb || busy_a !== 1'b0 || irq_a !== 1'b1) begin
            errors++; $display("FAIL enable_off got %0d accesses busy=%b irq=%b expected 0 0 1", bus_a - nb, busy_a, irq_a);
        end
        @(posedge clk); #1 en_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        b = {ifa.chipselect, ifa.write_n, ifa.address};
        checks++;
        if (b !== 4'b1011) begin errors++; $display("FAIL enable_ack got cs/wn/addr=%b expected 1011", b); end
        wait_drain_a(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL enable_drain_timeout got %0d pending expected 0", q_a.size()); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_wrap();
        bit ok;
        for (int i = 0; i < 5; i++) begin
            toggle_b();
            wait_drain_b(20, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL wrap_timeout event %0d got %0d pending expected 0", i, q_b.size()); end
            @(negedge clk);
            checks++;
            if (busy_b !== 1'b0) begin errors++; $display("FAIL wrap_no_holdoff event %0d got busy=%b expected 0", i, busy_b); end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_reset_emit();
        bit ok;
        logic [3:0] r;
        @(posedge clk); #1 ifa.event_ready = 1'b0;
        @(posedge clk); #1 pin_a = ~pin_a;
        wait_valid_a(15, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_emit_valid_timeout got valid=0 expected 1"); end
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        r = {ifa.event_valid, ifa.chipselect, busy_a, (ifa.event_count == 16'd0)};
        checks++;
        if (r !== 4'b0011) begin errors++; $display("FAIL rst_emit_values got valid/cs/busy/cnt0=%b expected 0011", r); end
        cnt_a = 0; cnt_b = 0;
        @(posedge clk); #1 reset_n = 1'b1; ifa.event_ready = 1'b1;
        check_init_sequence("rst_emit");
        toggle_a();
        wait_drain_a(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_emit_drain_timeout got %0d pending expected 0", q_a.size()); end
    endtask

    initial begin
        test_reset();
        test_service();
        test_backpressure();
        test_hold_toggle();
        test_enable();
        test_wrap();
        test_reset_emit();
        repeat (5) @(negedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++; $display("FAIL final_pending got a=%0d b=%0d expected 0 0", q_a.size(), q_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pio_irq_master.md
# pio_irq_master

Avalon-MM initiator that services the single-bit edge-capture PIO input slave. It arms the slave's interrupt mask after reset, then on each interrupt:
- clears the edge-capture register,
- reads back the current pin level,
- emits a level/sequence-number event on a valid/ready stream for downstream FIFO logic.

It sits between the PIO slave's s1 port and the event consumer. It replaces software interrupt servicing with fixed-latency hardware.

## Interface
- HOLDOFF, 4: idle cycles after each emitted event before irq is sampled again (0 allowed).
- CNT_W, 16: width of the event sequence counter.
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- enable  in  1  when low, the FSM stays in IDLE and ignores irq (init sequence still runs).
- irq  in  1  level interrupt from the PIO slave.
- readdata  in  32  slave read data, registered by the slave, valid one cycle after the address.
- address  out  2  slave register select: 0 = data, 2 = irq mask, 3 = edge capture.
- chipselect  out  1  bus access strobe.
- write_n  out  1  active-low write qualifier.
- writedata  out  32  write data.
- event_valid  out  1  event available.
- event_ready  in  1  consumer accepts the event when it is high with event_valid.
- event_level  out  1  pin level read after the clear.
- event_count  out  CNT_W  sequence number of the event, starting at 0.
- busy  out  1  high in every state except IDLE.

## Operation
- States: INIT_MASK → INIT_CLR → IDLE → ACK → RD → RD_CAP → EMIT → HOLD → IDLE.
- **INIT_MASK:** one write cycle, address=2, writedata=1.
- **INIT_CLR:** one write cycle, address=3, writedata=1 (discards edges latched before arming).
- **IDLE:** if enable && irq, go to ACK; otherwise stay.
- **ACK:** one write cycle, address=3, writedata=1.
  - The clear comes before the data read, so the level read is never older than the clear.
  - An edge arriving after the clear re-sets the capture register and causes another service pass.
- **RD:** chipselect=1, write_n=1, address=0.
- **RD_CAP:** bus idle; capture readdata[0] into the event_level register.
- **EMIT:** event_valid=1, stays until event_ready. On the handshake:
  - event_count increments (wraps modulo 2^CNT_W, no saturation);
  - go to HOLD.
  - event_level and event_count are held stable while event_valid is high.
- **HOLD:** count down HOLDOFF cycles, then IDLE. With HOLDOFF=0, go directly to IDLE.
- Bus idle value: chipselect=0, write_n=1, address=0, writedata=0.
- Writes are single-cycle: chipselect=1, write_n=0. The slave has no waitrequest, so every access completes in its cycle.
- Several edges between services collapse into one event; this is accepted.
- An edge landing exactly in an ACK/INIT_CLR write cycle is lost, because the slave's clear has priority; this is accepted.
- enable deasserted outside IDLE does not abort the current pass.

## Timing
- **Reset values:**
  - Bus outputs at idle value.
  - event_valid=0, event_level=0, event_count=0, busy=1.
  - State INIT_MASK.
- **Reset mid-operation:**
  - Immediate return to reset values.
  - Any pending event is dropped.
  - The init sequence repeats.
- **Init timing:** first cycle after reset release is INIT_MASK write; second is INIT_CLR write; IDLE from the third.
- **Service timing:** irq first seen high in IDLE at cycle t:
  - ACK write at t+1;
  - RD at t+2;
  - RD_CAP at t+3;
  - event_valid high from t+4.
- irq falls at t+2 as a consequence of the clear.
- **Throughput:** with event_ready tied high, at most one event per 5+HOLDOFF cycles.
- All outputs are registered or decoded from the state register only. There is no combinational path from irq or event_ready to any output.

## Structure
- Shared package holds:
  - state enum;
  - register address constants ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3;
  - the clear/mask writedata constant 1.
- Single module; no sub-module is warranted. The holdoff counter is an inline register of width $clog2(HOLDOFF+1), minimum 1.

## Test plan
- **Reset release:** bench sees write addr 2 data 1, then write addr 3 data 1, then busy=0 from cycle 3.
- **Pin 0→1 on slave model, event_ready=1:** write addr 3 data 1, read addr 0, event_valid one cycle with event_level=1, event_count=0; a second toggle to 0 gives level=0, count=1.
- **event_ready held low 10 cycles:** event_valid stays high, level/count stable, no further bus accesses; count increments only on the handshake.
- **CNT_W=2, 5 toggles:** counts 0,1,2,3,0.
- **Toggle during HOLD (HOLDOFF=4):** no bus activity until HOLD expires, then exactly one further service pass.
- **enable=0 with irq high:** no bus access for 20 cycles; enable=1 starts ACK the next cycle. reset_n pulsed during EMIT: event_valid drops and the init sequence restarts.
